// File: rtl/mib_pkg.sv
// Shared types for the move instruction bus issue path: opcodes, decoded entry,
// issue FSM states and the packed instruction field layout used by the fetch encoder.
package mib_pkg;

    localparam int unsigned MIB_ADDR_WIDTH  = 4;
    localparam int unsigned MIB_DATA_WIDTH  = 64;
    localparam int unsigned MIB_INSTR_WIDTH = 2 + 2 * MIB_ADDR_WIDTH + MIB_DATA_WIDTH;

    localparam int unsigned MIB_OP_LSB  = 0;
    localparam int unsigned MIB_DST_LSB = 2;
    localparam int unsigned MIB_SRC_LSB = MIB_DST_LSB + MIB_ADDR_WIDTH;
    localparam int unsigned MIB_IMM_LSB = MIB_SRC_LSB + MIB_ADDR_WIDTH;

    typedef enum logic [1:0] {
        MIB_OP_NOP  = 2'b00,
        MIB_OP_MOVE = 2'b01,
        MIB_OP_IMM  = 2'b10,
        MIB_OP_HALT = 2'b11
    } mib_opcode_e;

    typedef struct packed {
        mib_opcode_e                op;
        logic [MIB_ADDR_WIDTH-1:0]  src;
        logic [MIB_ADDR_WIDTH-1:0]  dst;
        logic [MIB_DATA_WIDTH-1:0]  imm;
    } mib_entry_t;

    typedef enum logic [1:0] {
        MIB_ST_IDLE       = 2'd0,
        MIB_ST_ISSUE_MOVE = 2'd1,
        MIB_ST_ISSUE_IMM  = 2'd2,
        MIB_ST_HALTED     = 2'd3
    } mib_state_e;

    // Unpack a fetch word into a decoded entry.
    function automatic mib_entry_t mib_decode(input logic [MIB_INSTR_WIDTH-1:0] word);
        mib_entry_t e;
        e.op  = mib_opcode_e'(word[MIB_OP_LSB +: 2]);
        e.dst = word[MIB_DST_LSB +: MIB_ADDR_WIDTH];
        e.src = word[MIB_SRC_LSB +: MIB_ADDR_WIDTH];
        e.imm = word[MIB_IMM_LSB +: MIB_DATA_WIDTH];
        return e;
    endfunction

endpackage

// File: rtl/instruction_interface.sv
// Control port of the move instruction bus: a producer issues moves/immediates,
// the MIB consumer acknowledges them.
interface instruction_interface #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  move_valid;
    logic [ADDR_WIDTH-1:0] move_from;
    logic [ADDR_WIDTH-1:0] move_to;
    logic                  move_ack;
    logic                  immediate_valid;
    logic [DATA_WIDTH-1:0] immediate;
    logic [ADDR_WIDTH-1:0] immediate_addr;
    logic                  immediate_ack;

    modport producer (
        output move_valid, move_from, move_to,
        output immediate_valid, immediate, immediate_addr,
        input  move_ack, immediate_ack
    );

    modport consumer (
        input  move_valid, move_from, move_to,
        input  immediate_valid, immediate, immediate_addr,
        output move_ack, immediate_ack
    );
endinterface

// File: rtl/mib_sync_fifo.sv
// Synchronous FIFO with count-based full/empty; exposes the head and the entry
// behind it so the consumer can look one pop ahead.
module mib_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output T                 second,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = pop && (r_count != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head   = r_mem[r_rd_ptr];
    assign second = r_mem[r_rd_ptr + PTR_W'(1)];
    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign count  = r_count;

endmodule

// File: rtl/mib_move_issuer.sv
// Issue stage in front of the move instruction bus: decodes fetch words, buffers
// them, and presents one MOVE/IMM at a time on the MIB control port until acked.
module mib_move_issuer
    import mib_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MIB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MIB_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned INSTR_WIDTH = 2 + 2 * ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    input  logic                   resume,
    instruction_interface.producer cu,
    output logic                   halted,
    output logic [31:0]            issued_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    mib_entry_t       w_in_entry;
    mib_entry_t       w_head;
    mib_entry_t       w_second;
    mib_entry_t       w_nxt_head;
    logic             w_nxt_avail;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_remain;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_halt_pop;
    logic             w_count_inc;
    logic             w_halt_pending_nxt;
    mib_state_e       w_state_nxt;

    mib_state_e            r_state;
    logic                  r_halt_pending;
    logic                  r_instr_ready;
    logic                  r_halted;
    logic [31:0]           r_issued_count;
    logic                  r_move_valid;
    logic [ADDR_WIDTH-1:0] r_move_from;
    logic [ADDR_WIDTH-1:0] r_move_to;
    logic                  r_imm_valid;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [ADDR_WIDTH-1:0] r_imm_addr;

    // Issue state implied by whatever entry will sit at the head after this edge.
    function automatic mib_state_e f_issue_state(input logic avail, input mib_entry_t e);
        if (!avail) return MIB_ST_IDLE;
        case (e.op)
            MIB_OP_MOVE: return MIB_ST_ISSUE_MOVE;
            MIB_OP_IMM:  return MIB_ST_ISSUE_IMM;
            default:     return MIB_ST_IDLE;
        endcase
    endfunction

    assign w_in_entry = mib_decode(instr_data);
    assign w_accept   = instr_valid && r_instr_ready;
    assign w_push     = w_accept && !w_full && (w_in_entry.op != MIB_OP_NOP);

    mib_sync_fifo #(
        .T     (mib_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_in_entry),
        .pop       (w_pop),
        .head      (w_head),
        .second    (w_second),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    // Next-state: pop decision first, then look ahead to the post-edge head so
    // a newly available entry drives the bus on the very next cycle.
    always_comb begin
        w_pop              = 1'b0;
        w_halt_pop         = 1'b0;
        w_count_inc        = 1'b0;
        w_nxt_avail        = 1'b0;
        w_nxt_head         = w_head;
        w_state_nxt        = r_state;
        w_halt_pending_nxt = r_halt_pending || (w_accept && (w_in_entry.op == MIB_OP_HALT));

        case (r_state)
            MIB_ST_IDLE: begin
                if (!w_empty && (w_head.op == MIB_OP_HALT)) begin
                    w_pop      = 1'b1;
                    w_halt_pop = 1'b1;
                end
            end
            MIB_ST_ISSUE_MOVE: begin
                if (cu.move_ack) begin
                    w_pop       = 1'b1;
                    w_count_inc = 1'b1;
                end
            end
            MIB_ST_ISSUE_IMM: begin
                if (cu.move_ack && cu.immediate_ack) begin
                    w_pop       = 1'b1;
                    w_count_inc = 1'b1;
                end
            end
            default: ;
        endcase

        w_remain = w_count - CNT_W'(w_pop);
        if (w_remain != '0) begin
            w_nxt_avail = 1'b1;
            w_nxt_head  = w_pop ? w_second : w_head;
        end else if (w_push) begin
            w_nxt_avail = 1'b1;
            w_nxt_head  = w_in_entry;
        end

        if (w_halt_pop) begin
            w_state_nxt = MIB_ST_HALTED;
        end else if (r_state != MIB_ST_HALTED) begin
            w_state_nxt = f_issue_state(w_nxt_avail, w_nxt_head);
        end else if (resume) begin
            w_halt_pending_nxt = 1'b0;
            w_state_nxt        = f_issue_state(w_nxt_avail, w_nxt_head);
        end

        w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= MIB_ST_IDLE;
            r_halt_pending <= 1'b0;
            r_instr_ready  <= 1'b0;
            r_halted       <= 1'b0;
            r_issued_count <= '0;
            r_move_valid   <= 1'b0;
            r_move_from    <= '0;
            r_move_to      <= '0;
            r_imm_valid    <= 1'b0;
            r_imm          <= '0;
            r_imm_addr     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_halt_pending <= w_halt_pending_nxt;
            r_halted       <= (w_state_nxt == MIB_ST_HALTED);
            r_instr_ready  <= (w_count_nxt != CNT_W'(DEPTH)) &&
                              (w_state_nxt != MIB_ST_HALTED) && !w_halt_pending_nxt;
            r_issued_count <= r_issued_count + 32'(w_count_inc);
            // Address fields hold when idle; the immediate is zeroed.
            case (w_state_nxt)
                MIB_ST_ISSUE_MOVE: begin
                    r_move_valid <= 1'b1;
                    r_move_from  <= w_nxt_head.src;
                    r_move_to    <= w_nxt_head.dst;
                    r_imm_valid  <= 1'b0;
                    r_imm        <= '0;
                end
                MIB_ST_ISSUE_IMM: begin
                    r_move_valid <= 1'b1;
                    r_move_from  <= '0;
                    r_move_to    <= w_nxt_head.dst;
                    r_imm_valid  <= 1'b1;
                    r_imm        <= w_nxt_head.imm;
                    r_imm_addr   <= w_nxt_head.dst;
                end
                default: begin
                    r_move_valid <= 1'b0;
                    r_imm_valid  <= 1'b0;
                    r_imm        <= '0;
                end
            endcase
        end
    end

    assign instr_ready        = r_instr_ready;
    assign halted             = r_halted;
    assign issued_count       = r_issued_count;
    assign cu.move_valid      = r_move_valid;
    assign cu.move_from       = r_move_from;
    assign cu.move_to         = r_move_to;
    assign cu.immediate_valid = r_imm_valid;
    assign cu.immediate       = r_imm;
    assign cu.immediate_addr  = r_imm_addr;

endmodule

// File: tb/tb_mib_move_issuer.sv
// Directed self-checking bench for mib_move_issuer.
module tb_mib_move_issuer;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_IMM  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    logic        clock;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [73:0] instr_data;
    logic        resume;
    logic        halted;
    logic [31:0] issued_count;

    int errors = 0;
    int checks = 0;

    instruction_interface #(.ADDR_WIDTH(4), .DATA_WIDTH(64)) cu_if ();

    mib_move_issuer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .resume       (resume),
        .cu           (cu_if),
        .halted       (halted),
        .issued_count (issued_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [73:0] enc(input logic [1:0] op, input logic [3:0] src,
                                        input logic [3:0] dst, input logic [63:0] imm);
        return {imm, src, dst, op};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        instr_valid      = 1'b0;
        instr_data       = '0;
        resume           = 1'b0;
        cu_if.move_ack      = 1'b0;
        cu_if.immediate_ack = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instr_valid = 1'b0; instr_data = '0; resume = 1'b0;
        cu_if.move_ack = 1'b0; cu_if.immediate_ack = 1'b0;
        tick(); tick();
        checks++;
        if ({instr_ready, cu_if.move_valid, cu_if.immediate_valid, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {instr_ready, cu_if.move_valid, cu_if.immediate_valid, halted});
        end
        checks++;
        if ({cu_if.move_from, cu_if.move_to, cu_if.immediate_addr, cu_if.immediate, issued_count} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got from=%h to=%h ia=%h imm=%h cnt=%h want all 0",
                     cu_if.move_from, cu_if.move_to, cu_if.immediate_addr, cu_if.immediate, issued_count);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_rise: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_single_move();
        do_reset();
        cu_if.move_ack = 1'b1;
        instr_valid = 1'b1; instr_data = enc(OP_MOVE, 4'd3, 4'd5, 64'd0);
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({instr_ready, cu_if.move_valid, cu_if.immediate_valid, cu_if.move_from, cu_if.move_to}
            !== {1'b1, 1'b1, 1'b0, 4'd3, 4'd5}) begin
            errors++;
            $display("FAIL single_issue: got rdy=%b mv=%b iv=%b from=%0d to=%0d want 1 1 0 3 5",
                     instr_ready, cu_if.move_valid, cu_if.immediate_valid, cu_if.move_from, cu_if.move_to);
        end
        tick();
        checks++;
        if ({instr_ready, cu_if.move_valid, cu_if.move_to, issued_count} !== {1'b1, 1'b0, 4'd5, 32'd1}) begin
            errors++;
            $display("FAIL single_done: got rdy=%b mv=%b to=%0d cnt=%0d want 1 0 5 1",
                     instr_ready, cu_if.move_valid, cu_if.move_to, issued_count);
        end
        tick();
        checks++;
        if ({cu_if.move_valid, issued_count} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL single_once: got mv=%b cnt=%0d want 0 1", cu_if.move_valid, issued_count);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            instr_valid = 1'b1; instr_data = enc(OP_MOVE, 4'(i), 4'(15 - i), 64'd0);
            tick();
        end
        checks++;
        if ({instr_ready, cu_if.move_valid, cu_if.move_from, cu_if.move_to} !== {1'b0, 1'b1, 4'd0, 4'd15}) begin
            errors++;
            $display("FAIL fill_full: got rdy=%b mv=%b from=%0d to=%0d want 0 1 0 15",
                     instr_ready, cu_if.move_valid, cu_if.move_from, cu_if.move_to);
        end
        instr_data = enc(OP_MOVE, 4'd9, 4'd9, 64'd0);
        tick();
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ninth: got rdy=%b want 0", instr_ready);
        end
        instr_valid = 1'b0;
        cu_if.move_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({cu_if.move_valid, cu_if.move_from, cu_if.move_to} !== {1'b1, 4'(k), 4'(15 - k)}) begin
                errors++;
                $display("FAIL drain_%0d: got mv=%b from=%0d to=%0d want 1 %0d %0d", k,
                         cu_if.move_valid, cu_if.move_from, cu_if.move_to, k, 15 - k);
            end
            tick();
        end
        checks++;
        if ({instr_ready, cu_if.move_valid, issued_count} !== {1'b1, 1'b0, 32'd8}) begin
            errors++;
            $display("FAIL drain_end: got rdy=%b mv=%b cnt=%0d want 1 0 8",
                     instr_ready, cu_if.move_valid, issued_count);
        end
    endtask

    task automatic test_imm();
        logic [63:0] v;
        v = 64'hDEAD_BEEF_0000_0001;
        do_reset();
        instr_valid = 1'b1; instr_data = enc(OP_IMM, 4'd7, 4'd2, v);
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({cu_if.move_valid, cu_if.immediate_valid, cu_if.move_from, cu_if.move_to,
             cu_if.immediate_addr, cu_if.immediate} !== {1'b1, 1'b1, 4'd0, 4'd2, 4'd2, v}) begin
            errors++;
            $display("FAIL imm_issue: got mv=%b iv=%b from=%0d to=%0d ia=%0d imm=%h want 1 1 0 2 2 %h",
                     cu_if.move_valid, cu_if.immediate_valid, cu_if.move_from, cu_if.move_to,
                     cu_if.immediate_addr, cu_if.immediate, v);
        end
        // move_ack alone, then immediate_ack alone for two cycles: no completion
        cu_if.move_ack = 1'b1;
        tick();
        cu_if.move_ack = 1'b0; cu_if.immediate_ack = 1'b1;
        tick();
        tick();
        checks++;
        if ({cu_if.move_valid, cu_if.immediate_valid, cu_if.move_to, cu_if.immediate_addr,
             cu_if.immediate, issued_count} !== {1'b1, 1'b1, 4'd2, 4'd2, v, 32'd0}) begin
            errors++;
            $display("FAIL imm_hold: got mv=%b iv=%b to=%0d ia=%0d imm=%h cnt=%0d want 1 1 2 2 %h 0",
                     cu_if.move_valid, cu_if.immediate_valid, cu_if.move_to, cu_if.immediate_addr,
                     cu_if.immediate, issued_count, v);
        end
        cu_if.move_ack = 1'b1;
        tick();
        checks++;
        if ({cu_if.move_valid, cu_if.immediate_valid, cu_if.immediate_addr, cu_if.immediate, issued_count}
            !== {1'b0, 1'b0, 4'd2, 64'd0, 32'd1}) begin
            errors++;
            $display("FAIL imm_done: got mv=%b iv=%b ia=%0d imm=%h cnt=%0d want 0 0 2 0 1",
                     cu_if.move_valid, cu_if.immediate_valid, cu_if.immediate_addr, cu_if.immediate, issued_count);
        end
        tick();
        checks++;
        if ({cu_if.move_valid, issued_count} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL imm_one_pop: got mv=%b cnt=%0d want 0 1", cu_if.move_valid, issued_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        cu_if.move_ack = 1'b1;
        instr_valid = 1'b1; instr_data = enc(OP_NOP, 4'd1, 4'd1, 64'd0);
        tick();
        checks++;
        if ({instr_ready, cu_if.move_valid} !== 2'b10) begin
            errors++; $display("FAIL halt_nop_dropped: got rdy=%b mv=%b want 1 0", instr_ready, cu_if.move_valid);
        end
        instr_data = enc(OP_MOVE, 4'd4, 4'd6, 64'd0);
        tick();
        checks++;
        if ({cu_if.move_valid, cu_if.move_from, cu_if.move_to} !== {1'b1, 4'd4, 4'd6}) begin
            errors++;
            $display("FAIL halt_first_move: got mv=%b from=%0d to=%0d want 1 4 6",
                     cu_if.move_valid, cu_if.move_from, cu_if.move_to);
        end
        instr_data = enc(OP_HALT, 4'd0, 4'd0, 64'd0);
        tick();
        checks++;
        if ({instr_ready, cu_if.move_valid, halted, issued_count} !== {1'b0, 1'b0, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL halt_accepted: got rdy=%b mv=%b halted=%b cnt=%0d want 0 0 0 1",
                     instr_ready, cu_if.move_valid, halted, issued_count);
        end
        // resume coincides with the HALT pop and must be ignored
        instr_data = enc(OP_MOVE, 4'd9, 4'd10, 64'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        checks++;
        if ({halted, instr_ready, cu_if.move_valid} !== 3'b100) begin
            errors++;
            $display("FAIL halt_state: got halted=%b rdy=%b mv=%b want 1 0 0",
                     halted, instr_ready, cu_if.move_valid);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if ({halted, instr_ready, cu_if.move_valid} !== 3'b010) begin
            errors++;
            $display("FAIL halt_resume: got halted=%b rdy=%b mv=%b want 0 1 0",
                     halted, instr_ready, cu_if.move_valid);
        end
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({cu_if.move_valid, cu_if.move_from, cu_if.move_to} !== {1'b1, 4'd9, 4'd10}) begin
            errors++;
            $display("FAIL halt_second_move: got mv=%b from=%0d to=%0d want 1 9 10",
                     cu_if.move_valid, cu_if.move_from, cu_if.move_to);
        end
        tick();
        checks++;
        if ({cu_if.move_valid, issued_count} !== {1'b0, 32'd2}) begin
            errors++; $display("FAIL halt_count: got mv=%b cnt=%0d want 0 2", cu_if.move_valid, issued_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cu_if.move_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_valid = 1'b1; instr_data = enc(OP_MOVE, 4'(k + 1), 4'(k + 8), 64'd0);
            tick();
            checks++;
            if ({instr_ready, cu_if.move_valid, cu_if.move_from, cu_if.move_to}
                !== {1'b1, 1'b1, 4'(k + 1), 4'(k + 8)}) begin
                errors++;
                $display("FAIL b2b_%0d: got rdy=%b mv=%b from=%0d to=%0d want 1 1 %0d %0d", k,
                         instr_ready, cu_if.move_valid, cu_if.move_from, cu_if.move_to, k + 1, k + 8);
            end
        end
        instr_valid = 1'b0;
        tick();
        checks++;
        if ({cu_if.move_valid, issued_count} !== {1'b0, 32'd4}) begin
            errors++; $display("FAIL b2b_end: got mv=%b cnt=%0d want 0 4", cu_if.move_valid, issued_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            instr_valid = 1'b1; instr_data = enc(OP_MOVE, 4'(i + 3), 4'(i + 4), 64'd0);
            tick();
        end
        instr_valid = 1'b0;
        reset_n = 1'b0;
        cu_if.move_ack = 1'b1;
        tick();
        checks++;
        if ({cu_if.move_valid, cu_if.immediate_valid, instr_ready, cu_if.move_from, issued_count}
            !== {1'b0, 1'b0, 1'b0, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_mid: got mv=%b iv=%b rdy=%b from=%0d cnt=%0d want 0 0 0 0 0",
                     cu_if.move_valid, cu_if.immediate_valid, instr_ready, cu_if.move_from, issued_count);
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({instr_ready, cu_if.move_valid} !== 2'b10) begin
            errors++; $display("FAIL rst_empty: got rdy=%b mv=%b want 1 0", instr_ready, cu_if.move_valid);
        end
        instr_valid = 1'b1; instr_data = enc(OP_MOVE, 4'd1, 4'd2, 64'd0);
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({cu_if.move_valid, cu_if.move_from, cu_if.move_to} !== {1'b1, 4'd1, 4'd2}) begin
            errors++;
            $display("FAIL rst_fresh: got mv=%b from=%0d to=%0d want 1 1 2",
                     cu_if.move_valid, cu_if.move_from, cu_if.move_to);
        end
        tick();
    endtask

    task automatic test_count_wrap();
        do_reset();
        cu_if.move_ack = 1'b1;
        dut.r_issued_count = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            instr_valid = 1'b1; instr_data = enc(OP_MOVE, 4'd2, 4'd3, 64'd0);
            tick();
            instr_valid = 1'b0;
            tick();
            checks++;
            if (issued_count !== ((k == 0) ? 32'hFFFF_FFFF : 32'h0)) begin
                errors++;
                $display("FAIL wrap_%0d: got %h want %h", k, issued_count,
                         (k == 0) ? 32'hFFFF_FFFF : 32'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_fill_drain();
        test_imm();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
